// File: rtl/l15_fetch_mem_arbiter_if.sv
// rtl/l15_fetch_mem_arbiter_if.sv - fetch/mem client and L1.5 transducer signal bundle
interface l15_fetch_mem_arbiter_if;
   logic [4:0]  fe_rqtype, mem_rqtype;
   logic [2:0]  fe_size, mem_size;
   logic [31:0] fe_address, mem_address;
   logic [63:0] fe_data, mem_data;
   logic        fe_val, mem_val;
   logic        fe_req_ack, mem_req_ack;
   logic        fe_ack, fe_header_ack, mem_ack, mem_header_ack;
   logic        fe_rsp_val, mem_rsp_val;
   logic [63:0] fe_rsp_data_0, fe_rsp_data_1, mem_rsp_data_0, mem_rsp_data_1;
   logic [3:0]  fe_rsp_returntype, mem_rsp_returntype;
   logic [4:0]  transducer_l15_rqtype;
   logic [2:0]  transducer_l15_size;
   logic [31:0] transducer_l15_address;
   logic [63:0] transducer_l15_data;
   logic        transducer_l15_val;
   logic        transducer_l15_req_ack;
   logic        l15_transducer_ack;
   logic        l15_transducer_header_ack;
   logic        l15_transducer_val;
   logic [63:0] l15_transducer_data_0, l15_transducer_data_1;
   logic [3:0]  l15_transducer_returntype;
   logic        arb_eqmem;
   logic        memOp_done;

   // Arbiter side
   modport slave (
      input  fe_rqtype, mem_rqtype, fe_size, mem_size, fe_address, mem_address,
             fe_data, mem_data, fe_val, mem_val, fe_req_ack, mem_req_ack,
             l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
             l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype,
      output fe_ack, fe_header_ack, mem_ack, mem_header_ack, fe_rsp_val, mem_rsp_val,
             fe_rsp_data_0, fe_rsp_data_1, mem_rsp_data_0, mem_rsp_data_1,
             fe_rsp_returntype, mem_rsp_returntype,
             transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
             transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
             arb_eqmem, memOp_done
   );

   // Client and L1.5 side
   modport master (
      output fe_rqtype, mem_rqtype, fe_size, mem_size, fe_address, mem_address,
             fe_data, mem_data, fe_val, mem_val, fe_req_ack, mem_req_ack,
             l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
             l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype,
      input  fe_ack, fe_header_ack, mem_ack, mem_header_ack, fe_rsp_val, mem_rsp_val,
             fe_rsp_data_0, fe_rsp_data_1, mem_rsp_data_0, mem_rsp_data_1,
             fe_rsp_returntype, mem_rsp_returntype,
             transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
             transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
             arb_eqmem, memOp_done
   );
endinterface

// File: rtl/l15_fetch_mem_arbiter.sv
// rtl/l15_fetch_mem_arbiter.sv - one-outstanding arbiter of fetch and mem clients onto the L1.5 port
module l15_fetch_mem_arbiter #(
   parameter logic RESET_PRIO_MEM = 1'b1
) (
   input  logic                    clk,
   input  logic                    nrst,
   l15_fetch_mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD, ARB_RESP} arb_state_t;

   arb_state_t state;
   logic       owner;        // 0 = fetch, 1 = mem
   logic       last_mem;     // last grant went to mem
   logic       mem_op_done_q;

   logic sol_type, sol_val, unsol_val;
   logic req_any, grant_mem, in_idle, sel_mem, active, resp_sol, owner_req_ack;

   // Response classification, idle-time grant and selected client
   always_comb begin
      sol_type      = (bus.l15_transducer_returntype == 4'b0000) ||
                      (bus.l15_transducer_returntype == 4'b0001) ||
                      (bus.l15_transducer_returntype == 4'b0100);
      sol_val       = bus.l15_transducer_val && sol_type;
      unsol_val     = bus.l15_transducer_val && !sol_type;
      req_any       = bus.fe_val || bus.mem_val;
      // With both requesting, the client that did not win last time goes first
      grant_mem     = bus.mem_val && !(bus.fe_val && last_mem);
      in_idle       = (state == ARB_IDLE);
      sel_mem       = in_idle ? grant_mem : owner;
      active        = !in_idle || req_any;
      resp_sol      = (state == ARB_RESP) && sol_val;
      owner_req_ack = owner ? bus.mem_req_ack : bus.fe_req_ack;
   end

   // Request path: selected client's fields, zero when nobody holds or requests the port
   always_comb begin
      bus.transducer_l15_rqtype  = '0;
      bus.transducer_l15_size    = '0;
      bus.transducer_l15_address = '0;
      bus.transducer_l15_data    = '0;
      if (active) begin
         bus.transducer_l15_rqtype  = sel_mem ? bus.mem_rqtype  : bus.fe_rqtype;
         bus.transducer_l15_size    = sel_mem ? bus.mem_size    : bus.fe_size;
         bus.transducer_l15_address = sel_mem ? bus.mem_address : bus.fe_address;
         bus.transducer_l15_data    = sel_mem ? bus.mem_data    : bus.fe_data;
      end
      // Once the header is taken the request is no longer presented
      bus.transducer_l15_val = in_idle ? req_any : (state == ARB_HOLD);
   end

   // Ack, response and req_ack routing
   always_comb begin
      bus.fe_ack          = bus.l15_transducer_ack        && active && !sel_mem;
      bus.mem_ack         = bus.l15_transducer_ack        && active &&  sel_mem;
      bus.fe_header_ack   = bus.l15_transducer_header_ack && active && !sel_mem;
      bus.mem_header_ack  = bus.l15_transducer_header_ack && active &&  sel_mem;
      // Unsolicited packets (wake-up, interrupts) always belong to fetch
      bus.fe_rsp_val      = unsol_val || (resp_sol && !owner);
      bus.mem_rsp_val     = resp_sol && owner;
      bus.fe_rsp_data_0   = bus.l15_transducer_data_0;
      bus.fe_rsp_data_1   = bus.l15_transducer_data_1;
      bus.mem_rsp_data_0  = bus.l15_transducer_data_0;
      bus.mem_rsp_data_1  = bus.l15_transducer_data_1;
      bus.fe_rsp_returntype  = bus.l15_transducer_returntype;
      bus.mem_rsp_returntype = bus.l15_transducer_returntype;
      if (unsol_val)
         bus.transducer_l15_req_ack = bus.fe_req_ack;
      else if (resp_sol)
         bus.transducer_l15_req_ack = owner_req_ack;
      else
         bus.transducer_l15_req_ack = 1'b0;
      bus.arb_eqmem  = in_idle ? bus.mem_val : owner;
      bus.memOp_done = mem_op_done_q;
   end

   // Transaction FSM: grant, wait for header ack, wait for solicited response
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state         <= ARB_IDLE;
         owner         <= 1'b0;
         last_mem      <= RESET_PRIO_MEM;
         mem_op_done_q <= 1'b0;
      end else begin
         mem_op_done_q <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (req_any) begin
                  owner    <= grant_mem;
                  last_mem <= grant_mem;
                  state    <= bus.l15_transducer_header_ack ? ARB_RESP : ARB_HOLD;
               end
            end
            ARB_HOLD: begin
               if (bus.l15_transducer_header_ack)
                  state <= ARB_RESP;
            end
            ARB_RESP: begin
               if (resp_sol && owner_req_ack) begin
                  state         <= ARB_IDLE;
                  mem_op_done_q <= owner;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l15_fetch_mem_arbiter.sv
// tb/tb_l15_fetch_mem_arbiter.sv - vector table and randomized model check of l15_fetch_mem_arbiter
module tb_l15_fetch_mem_arbiter;

   logic clk = 1'b0;
   logic nrst;
   int   tests = 0;
   int   fails = 0;

   l15_fetch_mem_arbiter_if bus ();

   l15_fetch_mem_arbiter #(.RESET_PRIO_MEM(1'b1)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, fe_v, mem_v, hdr, lv;
      logic [3:0]  rt;
      logic        fer, mr;
      logic        e_val;
      logic [31:0] e_addr;
      logic        e_fh, e_mh, e_fr, e_mr, e_ra, e_eq, e_dn;
   } vec_t;

   vec_t vt [20];

   // Transaction-level reference model state
   bit m_open, m_mem, m_acc, m_rr, m_done;
   bit n_open, n_mem, n_acc, n_rr, n_done;

   task automatic set_idle_inputs();
      bus.fe_val = 0; bus.mem_val = 0; bus.fe_req_ack = 0; bus.mem_req_ack = 0;
      bus.l15_transducer_ack = 0; bus.l15_transducer_header_ack = 0;
      bus.l15_transducer_val = 0; bus.l15_transducer_returntype = 4'h0;
      bus.l15_transducer_data_0 = 64'h0; bus.l15_transducer_data_1 = 64'h0;
   endtask

   task automatic model_reset();
      m_open = 0; m_mem = 0; m_acc = 0; m_rr = 1; m_done = 0;
   endtask

   // Expected outputs from the open transaction (if any) and current inputs; also
   // works out the transaction record for the next cycle.
   task automatic model_check(input int cyc);
      bit sol, uns, any, cur_mem, pres, e_val, e_ra, resp_ok, own_ack;
      logic [4:0]  e_rq;
      logic [2:0]  e_sz;
      logic [31:0] e_ad;
      logic [63:0] e_dt;
      string s;
      if (!nrst) model_reset();
      sol = bus.l15_transducer_val && (bus.l15_transducer_returntype inside {4'h0, 4'h1, 4'h4});
      uns = bus.l15_transducer_val && !sol;
      any = bus.fe_val || bus.mem_val;
      if (m_open) begin
         cur_mem = m_mem; pres = 1; e_val = !m_acc;
      end else begin
         // fetch loses a tie only when the previous winner was fetch
         if (bus.fe_val && bus.mem_val) cur_mem = !m_rr;
         else cur_mem = bus.mem_val;
         pres = any; e_val = any;
      end
      e_rq = !pres ? 5'h0  : cur_mem ? bus.mem_rqtype  : bus.fe_rqtype;
      e_sz = !pres ? 3'h0  : cur_mem ? bus.mem_size    : bus.fe_size;
      e_ad = !pres ? 32'h0 : cur_mem ? bus.mem_address : bus.fe_address;
      e_dt = !pres ? 64'h0 : cur_mem ? bus.mem_data    : bus.fe_data;
      resp_ok = m_open && m_acc && sol;
      own_ack = m_mem ? bus.mem_req_ack : bus.fe_req_ack;
      e_ra = uns ? bus.fe_req_ack : resp_ok ? own_ack : 1'b0;
      s = $sformatf("c%0d", cyc);
      chk({s, " rqtype"}, 64'(bus.transducer_l15_rqtype), 64'(e_rq));
      chk({s, " size"}, 64'(bus.transducer_l15_size), 64'(e_sz));
      chk({s, " address"}, 64'(bus.transducer_l15_address), 64'(e_ad));
      chk({s, " data"}, bus.transducer_l15_data, e_dt);
      chk({s, " l15_val"}, 64'(bus.transducer_l15_val), 64'(e_val));
      chk({s, " req_ack"}, 64'(bus.transducer_l15_req_ack), 64'(e_ra));
      chk({s, " acks"}, 64'({bus.fe_ack, bus.fe_header_ack, bus.mem_ack, bus.mem_header_ack}),
          64'({bus.l15_transducer_ack && pres && !cur_mem, bus.l15_transducer_header_ack && pres && !cur_mem,
               bus.l15_transducer_ack && pres && cur_mem,  bus.l15_transducer_header_ack && pres && cur_mem}));
      chk({s, " rsp_val"}, 64'({bus.fe_rsp_val, bus.mem_rsp_val}),
          64'({uns || (resp_ok && !m_mem), resp_ok && m_mem}));
      chk({s, " rsp_data"}, bus.mem_rsp_data_1 ^ bus.fe_rsp_data_0,
          bus.l15_transducer_data_1 ^ bus.l15_transducer_data_0);
      chk({s, " eqmem"}, 64'(bus.arb_eqmem), 64'(m_open ? m_mem : bus.mem_val));
      chk({s, " memOp_done"}, 64'(bus.memOp_done), 64'(m_done));
      n_open = m_open; n_mem = m_mem; n_acc = m_acc; n_rr = m_rr; n_done = 0;
      if (!m_open && any) begin
         n_open = 1; n_mem = cur_mem; n_rr = cur_mem; n_acc = bus.l15_transducer_header_ack;
      end else if (m_open && !m_acc && bus.l15_transducer_header_ack) begin
         n_acc = 1;
      end else if (resp_ok && own_ack) begin
         n_open = 0; n_done = m_mem;
      end
   endtask

   initial begin
      bus.fe_rqtype = 5'h01; bus.mem_rqtype = 5'h02;
      bus.fe_size = 3'h3;    bus.mem_size = 3'h2;
      bus.fe_address = 32'h40000000; bus.mem_address = 32'h80000010;
      bus.fe_data = 64'h1111; bus.mem_data = 64'h2222;
      set_idle_inputs();
      nrst = 0;

      //        rst fe mem hdr lv rt  fer mr | val addr          fh mh fr mr ra eq dn
      vt[0]  = '{0, 0, 0, 0, 1, 4'h7, 1, 0,  0, 32'h0,        0, 0, 1, 0, 1, 0, 0}; // wake-up
      vt[1]  = '{0, 0, 0, 0, 1, 4'h0, 1, 1,  0, 32'h0,        0, 0, 0, 0, 0, 0, 0}; // stray
      vt[2]  = '{0, 1, 0, 1, 0, 4'h0, 0, 0,  1, 32'h40000000, 1, 0, 0, 0, 0, 0, 0}; // fetch req
      vt[3]  = '{0, 0, 0, 0, 1, 4'h1, 1, 0,  0, 32'h40000000, 0, 0, 1, 0, 1, 0, 0}; // fetch rsp
      vt[4]  = '{0, 0, 0, 0, 0, 4'h0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 0, 0, 0};
      vt[5]  = '{1, 0, 0, 0, 0, 4'h0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 0, 0, 0}; // reset
      vt[6]  = '{0, 1, 1, 0, 0, 4'h0, 0, 0,  1, 32'h40000000, 0, 0, 0, 0, 0, 1, 0}; // contention
      vt[7]  = '{0, 1, 1, 1, 0, 4'h0, 0, 0,  1, 32'h40000000, 1, 0, 0, 0, 0, 0, 0};
      vt[8]  = '{0, 0, 1, 0, 1, 4'h4, 1, 0,  0, 32'h40000000, 0, 0, 1, 0, 1, 0, 0};
      vt[9]  = '{0, 0, 1, 1, 0, 4'h0, 0, 0,  1, 32'h80000010, 0, 1, 0, 0, 0, 1, 0}; // mem next
      vt[10] = '{0, 0, 0, 0, 1, 4'h0, 0, 1,  0, 32'h80000010, 0, 0, 0, 1, 1, 1, 0};
      vt[11] = '{0, 0, 0, 0, 0, 4'h0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 0, 0, 1}; // done pulse
      vt[12] = '{0, 0, 0, 0, 0, 4'h0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 0, 0, 0};
      vt[13] = '{0, 0, 1, 0, 0, 4'h0, 0, 0,  1, 32'h80000010, 0, 0, 0, 0, 0, 1, 0}; // delayed hdr
      vt[14] = '{0, 1, 1, 0, 0, 4'h0, 0, 0,  1, 32'h80000010, 0, 0, 0, 0, 0, 1, 0};
      vt[15] = '{0, 1, 1, 0, 0, 4'h0, 0, 0,  1, 32'h80000010, 0, 0, 0, 0, 0, 1, 0};
      vt[16] = '{0, 1, 0, 1, 0, 4'h0, 0, 0,  1, 32'h80000010, 0, 1, 0, 0, 0, 1, 0};
      vt[17] = '{0, 1, 0, 0, 1, 4'h7, 1, 0,  0, 32'h80000010, 0, 0, 1, 0, 1, 1, 0}; // unsol in RESP
      vt[18] = '{1, 0, 1, 0, 0, 4'h0, 0, 0,  1, 32'h80000010, 0, 0, 0, 0, 0, 1, 0}; // reset mid-op
      vt[19] = '{0, 0, 0, 0, 0, 4'h0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 0, 0, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset l15_val", 64'(bus.transducer_l15_val), 64'h0);
      chk("reset eqmem", 64'(bus.arb_eqmem), 64'h0);
      nrst = 1;

      for (int i = 0; i < 20; i++) begin
         nrst = !vt[i].rst;
         bus.fe_val = vt[i].fe_v; bus.mem_val = vt[i].mem_v;
         bus.l15_transducer_header_ack = vt[i].hdr; bus.l15_transducer_ack = vt[i].hdr;
         bus.l15_transducer_val = vt[i].lv; bus.l15_transducer_returntype = vt[i].rt;
         bus.fe_req_ack = vt[i].fer; bus.mem_req_ack = vt[i].mr;
         @(negedge clk);
         chk($sformatf("v%0d l15_val", i), 64'(bus.transducer_l15_val), 64'(vt[i].e_val));
         chk($sformatf("v%0d address", i), 64'(bus.transducer_l15_address), 64'(vt[i].e_addr));
         chk($sformatf("v%0d hdr_acks", i), 64'({bus.fe_header_ack, bus.mem_header_ack}),
             64'({vt[i].e_fh, vt[i].e_mh}));
         chk($sformatf("v%0d rsp_val", i), 64'({bus.fe_rsp_val, bus.mem_rsp_val}),
             64'({vt[i].e_fr, vt[i].e_mr}));
         chk($sformatf("v%0d req_ack", i), 64'(bus.transducer_l15_req_ack), 64'(vt[i].e_ra));
         chk($sformatf("v%0d eqmem", i), 64'(bus.arb_eqmem), 64'(vt[i].e_eq));
         chk($sformatf("v%0d memOp_done", i), 64'(bus.memOp_done), 64'(vt[i].e_dn));
         @(posedge clk);
         #1;
      end

      // Randomized traffic against the transaction-level model
      set_idle_inputs();
      nrst = 0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      nrst = 1;
      for (int c = 0; c < 3000; c++) begin
         nrst = ($urandom_range(0, 149) != 0);
         bus.fe_val = $urandom_range(0, 1); bus.mem_val = $urandom_range(0, 1);
         bus.fe_rqtype = 5'($urandom); bus.mem_rqtype = 5'($urandom);
         bus.fe_size = 3'($urandom); bus.mem_size = 3'($urandom);
         bus.fe_address = $urandom; bus.mem_address = $urandom;
         bus.fe_data = {$urandom, $urandom}; bus.mem_data = {$urandom, $urandom};
         bus.fe_req_ack = ($urandom_range(0, 3) != 0); bus.mem_req_ack = ($urandom_range(0, 3) != 0);
         bus.l15_transducer_header_ack = $urandom_range(0, 1);
         bus.l15_transducer_ack = $urandom_range(0, 1);
         bus.l15_transducer_val = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 4))
            0: bus.l15_transducer_returntype = 4'h0;
            1: bus.l15_transducer_returntype = 4'h1;
            2: bus.l15_transducer_returntype = 4'h4;
            3: bus.l15_transducer_returntype = 4'h7;
            default: bus.l15_transducer_returntype = 4'h2;
         endcase
         bus.l15_transducer_data_0 = {$urandom, $urandom};
         bus.l15_transducer_data_1 = {$urandom, $urandom};
         @(negedge clk);
         model_check(c);
         @(posedge clk);
         if (nrst) begin
            m_open = n_open; m_mem = n_mem; m_acc = n_acc; m_rr = n_rr; m_done = n_done;
         end else begin
            model_reset();
         end
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
